amplitude_scaler: RTL and testbench
===================================

Name: amplitude_scaler

Overview:
Parametrised, registered successor to the 2-bit amplitude selector in the waveform-generator datapath. Sits between the waveform source (counter/LUT) and the DAC output register. Scales each sample by 2^-shift and supports offset-binary (mid-scale centred) scaling. Amplitude changes are ramped one shift step per RAMP_DIV samples to avoid output discontinuities.

Parameters:
WIDTH, 8, sample width in bits (>=4)
SEL_W, 3, width of amplitude select; constraint 2**SEL_W-1 <= WIDTH-1
RAMP_DIV, 16, accepted samples per one-step shift change (>=1)
CENTERED, 0, 0 = unsigned scaling toward 0; 1 = offset-binary scaling toward mid-scale 2**(WIDTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  data_in holds a new sample this cycle
data_in  in  WIDTH  input sample (unsigned or offset-binary per CENTERED)
amp_sel  in  SEL_W  target attenuation shift; 0 = full scale
out_valid  out  1  data_out holds a new scaled sample
data_out  out  WIDTH  scaled sample
cur_sel  out  SEL_W  shift currently applied
busy  out  1  high while cur_sel != amp_sel (ramp in progress)

Behaviour:
- Reset (rst high at clk edge): out_valid=0, data_out=0, cur_sel=0, ramp counter=0. busy is combinational (cur_sel != amp_sel), so it reads 0 after reset only when amp_sel=0. rst has priority over all other activity, including mid-ramp.
- Latency: 1 cycle. out_valid(t+1) = in_valid(t). data_out updates only when in_valid=1 and holds otherwise.
- Scaling uses cur_sel as it was before any update in the same cycle.
  - CENTERED=0: data_out = data_in >> cur_sel (logical shift).
  - CENTERED=1: d = data_in - 2**(WIDTH-1), taken as a signed WIDTH-bit value. data_out = (d >>> cur_sel) + 2**(WIDTH-1). The result always fits and never wraps.
- amp_sel is not registered. It is compared with cur_sel every cycle. All SEL_W values are legal.
- Ramp FSM, two states:
  - STEADY (cur_sel == amp_sel): counter is held at 0.
  - RAMP (cur_sel != amp_sel): each accepted sample (in_valid=1) increments the counter. On the accepted sample where counter == RAMP_DIV-1:
    - counter returns to 0;
    - cur_sel steps by ±1 toward amp_sel;
    - FSM moves to STEADY if the new value equals amp_sel.
  - Cycles with in_valid=0 never advance the ramp.
- RAMP_DIV=1: cur_sel steps on every accepted sample.
- If amp_sel changes during a ramp, the direction is re-evaluated each cycle and the counter is not cleared.
- If amp_sel returns to cur_sel mid-ramp, the FSM goes to STEADY immediately and the counter is cleared to 0.
- Full-scale (cur_sel=0) and maximum-attenuation boundaries: cur_sel never steps past amp_sel, so it cannot wrap.

Test Plan:
1. Reset, WIDTH=8, CENTERED=0, RAMP_DIV=4, amp_sel=0, in_valid=1, data_in=0x40 -> out_valid rises 1 cycle after rst drops; data_out=0x40, busy=0, cur_sel=0.
2. Same setup, set amp_sel=3 with continuous in_valid -> data_out shows 4×0x40, 4×0x20, 4×0x10, then 0x08 steady; busy drops when cur_sel=3.
3. Ramp pause: as in test 2 but deassert in_valid for 5 cycles after the 2nd sample -> out_valid=0 and data_out held during the gap; the ramp resumes needing 2 more samples at 0x40.
4. Mid-ramp reversal: cur_sel=2 ramping to 5; change amp_sel to 0 -> cur_sel steps 2→1→0 at RAMP_DIV-sample spacing, then busy=0.
5. CENTERED=1, amp_sel=cur_sel=1 -> data_in 0xC0→0xA0, 0x00→0x40, 0x80→0x80, 0xFF→0xBF.
6. Assert rst during a ramp (cur_sel=2, target 3) -> next cycle out_valid=0, data_out=0, cur_sel=0; the ramp restarts from 0 toward amp_sel.

Source files
------------

// File: rtl/amplitude_scaler.sv
// Registered amplitude scaler: attenuates each sample by 2^-cur_sel, either toward zero
// or toward mid-scale, and ramps cur_sel one step per RAMP_DIV accepted samples.
module amplitude_scaler #(
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 3,
  parameter int RAMP_DIV = 16,
  parameter int CENTERED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] amp_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy
);

  localparam int               CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    ST_STEADY,
    ST_RAMP
  } state_t;

  // Offset-binary: flipping the MSB converts to/from two's complement, so the
  // arithmetic shift moves the sample toward mid-scale and can never wrap.
  function automatic logic [WIDTH-1:0] scale_sample(input logic [WIDTH-1:0] x,
                                                    input logic [SEL_W-1:0] sh);
    logic signed [WIDTH-1:0] d;
    logic [WIDTH-1:0]        res;
    d = $signed(x ^ MID);
    if (CENTERED != 0) begin
      res = $unsigned(d >>> sh) ^ MID;
    end else begin
      res = x >> sh;
    end
    return res;
  endfunction

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic [SEL_W-1:0] r_cur_sel;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state;
  logic             w_step_up;
  logic [SEL_W-1:0] w_cur_sel_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // amp_sel is unregistered, so the state follows the live comparison each cycle;
  // a target that returns to cur_sel drops straight into STEADY and clears the count.
  always_comb begin
    w_state       = (r_cur_sel == amp_sel) ? ST_STEADY : ST_RAMP;
    w_step_up     = (amp_sel > r_cur_sel);
    w_cur_sel_nxt = r_cur_sel;
    w_cnt_nxt     = r_cnt;
    case (w_state)
      ST_STEADY: w_cnt_nxt = '0;
      ST_RAMP: begin
        if (in_valid) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt     = '0;
            w_cur_sel_nxt = w_step_up ? (r_cur_sel + 1'b1) : (r_cur_sel - 1'b1);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  // Stage p0 -> p1: scale with the pre-update shift, register with its valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_cur_sel <= '0;
      r_cnt     <= '0;
    end else begin
      r_vld_p1  <= in_valid;
      if (in_valid) begin
        r_data_p1 <= scale_sample(data_in, r_cur_sel);
      end
      r_cur_sel <= w_cur_sel_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign out_valid = r_vld_p1;
  assign data_out  = r_data_p1;
  assign cur_sel   = r_cur_sel;
  assign busy      = (r_cur_sel != amp_sel);

endmodule

// File: tb/tb_amplitude_scaler.sv
// Scoreboard bench: dut 0 is unsigned with RAMP_DIV=4, dut 1 is offset-binary with RAMP_DIV=1.
module tb_amplitude_scaler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iv[2];
  logic [7:0] din[2];
  logic [2:0] asel[2];
  logic       ov[2];
  logic [7:0] dout[2];
  logic [2:0] cs[2];
  logic       bz[2];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         m_cur[2];
  int         m_cnt[2];
  logic [7:0] m_last[2];
  logic       m_vld[2];

  always #5 clk = ~clk;

  amplitude_scaler #(.WIDTH(8), .SEL_W(3), .RAMP_DIV(4), .CENTERED(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .data_in(din[0]), .amp_sel(asel[0]),
    .out_valid(ov[0]), .data_out(dout[0]), .cur_sel(cs[0]), .busy(bz[0])
  );

  amplitude_scaler #(.WIDTH(8), .SEL_W(3), .RAMP_DIV(1), .CENTERED(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .data_in(din[1]), .amp_sel(asel[1]),
    .out_valid(ov[1]), .data_out(dout[1]), .cur_sel(cs[1]), .busy(bz[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rd_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Reference scaling in plain integer arithmetic (floor division for negatives).
  function automatic logic [7:0] ref_scale(input int k, input logic [7:0] x, input int s);
    int p, d, r;
    p = 1 << s;
    if (k == 0) begin
      r = int'(x) / p;
    end else begin
      d = int'(x) - 128;
      if (d >= 0) r = d / p;
      else        r = -((-d + p - 1) / p);
      r = r + 128;
    end
    return r[7:0];
  endfunction

  task automatic tick();
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = iv[k];
      if (iv[k]) begin
        e = ref_scale(k, din[k], m_cur[k]);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (m_cur[k] == int'(asel[k])) begin
        m_cnt[k] = 0;
      end else if (m_vld[k]) begin
        if (m_cnt[k] == rd_of(k) - 1) begin
          m_cnt[k] = 0;
          m_cur[k] = (int'(asel[k]) > m_cur[k]) ? m_cur[k] + 1 : m_cur[k] - 1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      check($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(m_vld[k]));
      if (m_vld[k]) begin
        if (k == 0 && q0.size() > 0)      m_last[k] = q0.pop_front();
        else if (k == 1 && q1.size() > 0) m_last[k] = q1.pop_front();
        else check($sformatf("sb_empty%0d", k), 32'd1, 32'd0);
      end
      check($sformatf("data_out%0d", k), 32'(dout[k]), 32'(m_last[k]));
      check($sformatf("cur_sel%0d", k), 32'(cs[k]), 32'(m_cur[k]));
      check($sformatf("busy%0d", k), 32'(bz[k]), 32'(m_cur[k] != int'(asel[k])));
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_data%0d", k), 32'(dout[k]), 32'd0);
      check($sformatf("rst_cur%0d", k), 32'(cs[k]), 32'd0);
      m_cur[k]  = 0;
      m_cnt[k]  = 0;
      m_last[k] = 8'h00;
    end
    q0.delete();
    q1.delete();
    rst = 1'b0;
  endtask

  task automatic drive(input int k, input logic v, input logic [7:0] d, input logic [2:0] s);
    iv[k]     = v;
    din[k]    = d;
    asel[k]   = s;
    iv[1 - k] = 1'b0;
    tick();
  endtask

  logic [7:0] c_in[4]  = '{8'hC0, 8'h00, 8'h80, 8'hFF};
  logic [7:0] c_exp[4] = '{8'hA0, 8'h40, 8'h80, 8'hBF};

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; din[k] = 8'h00; asel[k] = 3'd0;
    end
    iv[0] = 1'b1; din[0] = 8'h40;
    do_reset(2);

    // Full scale after reset
    drive(0, 1'b1, 8'h40, 3'd0);
    check("t1_data", 32'(dout[0]), 32'h40);
    check("t1_busy", 32'(bz[0]), 32'd0);
    drive(0, 1'b1, 8'h40, 3'd0);

    // Ramp 0 -> 3 with continuous samples
    repeat (13) drive(0, 1'b1, 8'h40, 3'd3);
    check("t2_cur", 32'(cs[0]), 32'd3);
    check("t2_data", 32'(dout[0]), 32'h08);
    check("t2_busy", 32'(bz[0]), 32'd0);

    // Ramp pause: gaps never advance the counter
    do_reset(1);
    drive(0, 1'b1, 8'h40, 3'd0);
    repeat (2) drive(0, 1'b1, 8'h40, 3'd3);
    repeat (5) drive(0, 1'b0, 8'h55, 3'd3);
    check("t3_hold", 32'(dout[0]), 32'h40);
    check("t3_cur_gap", 32'(cs[0]), 32'd0);
    repeat (2) drive(0, 1'b1, 8'h40, 3'd3);
    check("t3_data", 32'(dout[0]), 32'h40);
    check("t3_cur", 32'(cs[0]), 32'd1);
    repeat (10) drive(0, 1'b1, 8'h40, 3'd3);

    // Mid-ramp reversal keeps the count
    do_reset(1);
    repeat (10) drive(0, 1'b1, 8'hF0, 3'd5);
    check("t4_cur2", 32'(cs[0]), 32'd2);
    repeat (2) drive(0, 1'b1, 8'hF0, 3'd0);
    check("t4_cur1", 32'(cs[0]), 32'd1);
    repeat (4) drive(0, 1'b1, 8'hF0, 3'd0);
    check("t4_cur0", 32'(cs[0]), 32'd0);
    check("t4_busy", 32'(bz[0]), 32'd0);

    // Target returns to cur_sel: count cleared
    repeat (2) drive(0, 1'b1, 8'h80, 3'd1);
    drive(0, 1'b0, 8'h80, 3'd0);
    repeat (3) drive(0, 1'b1, 8'h80, 3'd1);
    check("ret_cur0", 32'(cs[0]), 32'd0);
    drive(0, 1'b1, 8'h80, 3'd1);
    check("ret_cur1", 32'(cs[0]), 32'd1);

    // Reset mid-ramp restarts from 0
    do_reset(1);
    repeat (10) drive(0, 1'b1, 8'h40, 3'd3);
    check("t6_cur_pre", 32'(cs[0]), 32'd2);
    iv[0] = 1'b1;
    do_reset(1);
    repeat (3) drive(0, 1'b1, 8'h40, 3'd3);
    check("t6_cur_hold", 32'(cs[0]), 32'd0);
    drive(0, 1'b1, 8'h40, 3'd3);
    check("t6_cur_step", 32'(cs[0]), 32'd1);

    // Offset-binary scaling at shift 1
    drive(1, 1'b1, 8'h80, 3'd1);
    check("t5_cur", 32'(cs[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, c_in[i], 3'd1);
      check($sformatf("t5_data%0d", i), 32'(dout[1]), 32'(c_exp[i]));
    end

    // Maximum attenuation and back, one step per sample
    repeat (8) drive(1, 1'b1, 8'h00, 3'd7);
    check("max_cur", 32'(cs[1]), 32'd7);
    check("max_data", 32'(dout[1]), 32'h7F);
    repeat (8) drive(1, 1'b1, 8'hFF, 3'd0);
    check("min_cur", 32'(cs[1]), 32'd0);

    // Random traffic on both instances
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]  = ($urandom_range(0, 3) != 0);
        din[k] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 24) == 0) asel[k] = 3'($urandom_range(0, 7));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
